// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and geometry helpers for the window gatherer
package pool_pkg;

  typedef enum logic {FILL, DRAIN} state_t;

  function automatic int win_beats(input int k);
    return k * k;
  endfunction

  function automatic int win_per_band(input int k, input int w);
    return w / k;
  endfunction

  function automatic int bands(input int k, input int h);
    return h / k;
  endfunction

  function automatic int buf_depth(input int k, input int w);
    return k * w;
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Flat buffer index of a pixel at (row within band, column).
  function automatic int buf_addr(input int row, input int col, input int img_width);
    return row * img_width + col;
  endfunction

endpackage

// File: rtl/pool_window_gather_row_buffer.sv
// rtl/pool_window_gather_row_buffer.sv - band buffer, one write port, one combinational read port
module pool_row_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_gather.sv
// rtl/pool_window_gather.sv - buffers one band of rows and re-emits it as stride-K KxK windows
module pool_window_gather
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic                  tlast_err
);

  localparam int WIN_PER_BAND = win_per_band(KERNEL_SIZE, IMG_WIDTH);
  localparam int BANDS        = bands(KERNEL_SIZE, IMG_HEIGHT);
  localparam int BUF_DEPTH    = buf_depth(KERNEL_SIZE, IMG_WIDTH);
  localparam int COL_W        = cnt_w(IMG_WIDTH);
  localparam int ROW_W        = cnt_w(KERNEL_SIZE);
  localparam int BAND_W       = cnt_w(BANDS);
  localparam int WX_W         = cnt_w(WIN_PER_BAND);
  localparam int ADDR_W       = cnt_w(BUF_DEPTH);

  if (KERNEL_SIZE < 2) begin : g_bad_kernel
    $error("KERNEL_SIZE must be at least 2");
  end
  if (IMG_WIDTH % KERNEL_SIZE != 0) begin : g_bad_width
    $error("IMG_WIDTH must be a multiple of KERNEL_SIZE");
  end
  if (IMG_HEIGHT % KERNEL_SIZE != 0) begin : g_bad_height
    $error("IMG_HEIGHT must be a multiple of KERNEL_SIZE");
  end

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [BAND_W-1:0] band;
  logic [WX_W-1:0]   wx, wx_n, rd_wx;
  logic [ROW_W-1:0]  ky, kx, ky_n, kx_n, rd_ky, rd_kx;

  logic in_hs, out_hs, fill_last, frame_last_pix, band_last_beat, rd_last;
  logic [ADDR_W-1:0]     waddr, raddr;
  logic [DATA_WIDTH-1:0] rdata;

  assign s_axis_tready  = (state == FILL) && !reset;
  assign in_hs          = s_axis_tvalid && s_axis_tready;
  assign out_hs         = m_axis_tvalid && m_axis_tready;
  assign fill_last      = (row == ROW_W'(KERNEL_SIZE - 1)) && (col == COL_W'(IMG_WIDTH - 1));
  assign frame_last_pix = fill_last && (band == BAND_W'(BANDS - 1));
  assign band_last_beat = (ky == ROW_W'(KERNEL_SIZE - 1)) && (kx == ROW_W'(KERNEL_SIZE - 1))
                          && (wx == WX_W'(WIN_PER_BAND - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (in_hs && fill_last)       state_nxt = DRAIN;
      DRAIN: if (out_hs && band_last_beat) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Position of the beat that follows the one currently held in the output register.
  always_comb begin
    kx_n = kx + ROW_W'(1);
    ky_n = ky;
    wx_n = wx;
    if (kx == ROW_W'(KERNEL_SIZE - 1)) begin
      kx_n = '0;
      if (ky == ROW_W'(KERNEL_SIZE - 1)) begin
        ky_n = '0;
        wx_n = wx + WX_W'(1);
      end else begin
        ky_n = ky + ROW_W'(1);
      end
    end
  end

  // While filling, the read port is parked on the first beat of the band.
  assign rd_ky   = (state == FILL) ? '0 : ky_n;
  assign rd_kx   = (state == FILL) ? '0 : kx_n;
  assign rd_wx   = (state == FILL) ? '0 : wx_n;
  assign rd_last = (rd_ky == ROW_W'(KERNEL_SIZE - 1)) && (rd_kx == ROW_W'(KERNEL_SIZE - 1));

  assign waddr = ADDR_W'(buf_addr(int'(row), int'(col), IMG_WIDTH));
  assign raddr = ADDR_W'(buf_addr(int'(rd_ky), int'(rd_wx) * KERNEL_SIZE + int'(rd_kx), IMG_WIDTH));

  pool_row_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_row_buffer (
    .clk   (clk),
    .we    (in_hs),
    .waddr (waddr),
    .wdata (s_axis_tdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col           <= '0;
      row           <= '0;
      band          <= '0;
      wx            <= '0;
      ky            <= '0;
      kx            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_hs) begin
        if (s_axis_tlast != frame_last_pix) tlast_err <= 1'b1;
        if (col == COL_W'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(KERNEL_SIZE - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (fill_last) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= rdata;
          m_axis_tlast  <= rd_last;
          wx            <= '0;
          ky            <= '0;
          kx            <= '0;
        end
      end
      if (out_hs) begin
        if (band_last_beat) begin
          m_axis_tvalid <= 1'b0;
          if (band == BAND_W'(BANDS - 1)) begin
            band       <= '0;
            frame_done <= 1'b1;
          end else begin
            band <= band + BAND_W'(1);
          end
        end else begin
          m_axis_tdata <= rdata;
          m_axis_tlast <= rd_last;
          wx           <= wx_n;
          ky           <= ky_n;
          kx           <= kx_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gather.sv
// tb/tb_pool_window_gather.sv - scoreboard bench for pool_window_gather (2x2 on 4x4, 3x3 on 6x3)
module tb_pool_window_gather;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic s_tvalid, s_tlast, m_tready;
  logic [31:0] s_tdata;

  logic a_s_tready, a_m_tvalid, a_m_tlast, a_fd, a_err;
  logic b_s_tready, b_m_tvalid, b_m_tlast, b_fd, b_err;
  logic [31:0] a_m_tdata, b_m_tdata;

  logic cur_s_tready, cur_m_tvalid, cur_m_tlast, cur_fd, cur_err;
  logic [31:0] cur_m_tdata;

  int vectors = 0;
  int miscompares = 0;
  bit in_drain;
  bit exp_err;
  logic [31:0] q_data[$];
  bit          q_last[$];

  always #5 clk = ~clk;

  pool_window_gather #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (sel ? 1'b0 : s_tvalid),
    .s_axis_tready (a_s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (a_m_tvalid),
    .m_axis_tready (sel ? 1'b0 : m_tready),
    .m_axis_tdata  (a_m_tdata),
    .m_axis_tlast  (a_m_tlast),
    .frame_done    (a_fd),
    .tlast_err     (a_err)
  );

  pool_window_gather #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .IMG_WIDTH(6), .IMG_HEIGHT(3)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (sel ? s_tvalid : 1'b0),
    .s_axis_tready (b_s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (b_m_tvalid),
    .m_axis_tready (sel ? m_tready : 1'b0),
    .m_axis_tdata  (b_m_tdata),
    .m_axis_tlast  (b_m_tlast),
    .frame_done    (b_fd),
    .tlast_err     (b_err)
  );

  assign cur_s_tready = sel ? b_s_tready : a_s_tready;
  assign cur_m_tvalid = sel ? b_m_tvalid : a_m_tvalid;
  assign cur_m_tdata  = sel ? b_m_tdata  : a_m_tdata;
  assign cur_m_tlast  = sel ? b_m_tlast  : a_m_tlast;
  assign cur_fd       = sel ? b_fd       : a_fd;
  assign cur_err      = sel ? b_err      : a_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_tready_low", {31'd0, cur_s_tready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_m_tvalid", {31'd0, cur_m_tvalid}, 32'd0);
    chk("rst_m_tdata", cur_m_tdata, 32'd0);
    chk("rst_m_tlast", {31'd0, cur_m_tlast}, 32'd0);
    chk("rst_frame_done", {31'd0, cur_fd}, 32'd0);
    chk("rst_tlast_err", {31'd0, cur_err}, 32'd0);
    chk("rst_s_tready_fill", {31'd0, cur_s_tready}, 32'd1);
    in_drain = 1'b0;
    exp_err  = 1'b0;
    q_data.delete();
    q_last.delete();
  endtask

  // Streams one frame of pixels base..base+n-1 and checks every output cycle.
  task automatic run_frame(input int base, input int bad_pos, input bit drop_last,
                           input bit toggle, input int abort_after);
    int k, w, h, n, pix, beats, cyc;
    bit prev_stall, exp_fd, next_fd, in_hs, out_hs;
    logic [31:0] prev_data;
    logic prev_last;
    k = sel ? 3 : 2;
    w = sel ? 6 : 4;
    h = sel ? 3 : 4;
    n = w * h;
    for (int b = 0; b < h / k; b++)
      for (int wx = 0; wx < w / k; wx++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            q_data.push_back(32'(base + (b * k + ky) * w + wx * k + kx));
            q_last.push_back((ky == k - 1) && (kx == k - 1));
          end
    pix = 0; beats = 0; cyc = 0;
    prev_stall = 1'b0; exp_fd = 1'b0; prev_data = '0; prev_last = 1'b0;
    forever begin
      s_tvalid = (pix < n);
      s_tdata  = 32'(base + pix);
      s_tlast  = (pix < n) && ((pix == bad_pos) || ((pix == n - 1) && !drop_last));
      m_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      chk("s_tready", {31'd0, cur_s_tready}, {31'd0, !in_drain});
      chk("m_tvalid", {31'd0, cur_m_tvalid}, {31'd0, in_drain});
      chk("frame_done", {31'd0, cur_fd}, {31'd0, exp_fd});
      chk("tlast_err", {31'd0, cur_err}, {31'd0, exp_err});
      if (prev_stall) begin
        chk("stall_tdata", cur_m_tdata, prev_data);
        chk("stall_tlast", {31'd0, cur_m_tlast}, {31'd0, prev_last});
      end
      if (pix >= n && q_data.size() == 0 && !in_drain) break;
      in_hs   = s_tvalid && cur_s_tready;
      out_hs  = cur_m_tvalid && m_tready;
      next_fd = 1'b0;
      if (out_hs) begin
        if (q_data.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("m_tdata", cur_m_tdata, q_data.pop_front());
          chk("m_tlast", {31'd0, cur_m_tlast}, {31'd0, q_last.pop_front()});
        end
        beats++;
        if (beats % (w * k) == 0) in_drain = 1'b0;
        if (beats == n) next_fd = 1'b1;
      end
      if (in_hs) begin
        if (s_tlast != (pix == n - 1)) exp_err = 1'b1;
        if ((pix % (k * w)) == k * w - 1) in_drain = 1'b1;
        pix++;
      end
      prev_stall = cur_m_tvalid && !m_tready;
      prev_data  = cur_m_tdata;
      prev_last  = cur_m_tlast;
      exp_fd     = next_fd;
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && beats == abort_after) return;
      if (cyc > 2000) begin
        chk("timeout", 32'd1, 32'd0);
        return;
      end
    end
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("frame_done_single", {31'd0, cur_fd}, 32'd0);
  endtask

  initial begin
    sel      = 1'b0;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    do_reset();
    run_frame(0, -1, 1'b0, 1'b0, 0);
    run_frame(0, -1, 1'b0, 1'b1, 0);
    run_frame(0, 10, 1'b1, 1'b0, 0);
    chk("tlast_err_sticky", {31'd0, cur_err}, 32'd1);
    run_frame(200, -1, 1'b0, 1'b0, 3);
    do_reset();
    run_frame(100, -1, 1'b0, 1'b0, 0);
    sel = 1'b1;
    in_drain = 1'b0;
    exp_err  = 1'b0;
    #1;
    run_frame(0, -1, 1'b0, 1'b0, 0);
    run_frame(0, -1, 1'b0, 1'b1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
